snake_head_mover: RTL and testbench

- Downstream consumer of the 3-bit direction code produced by the button-direction stage.
- Runs the game-step prescaler, commits the requested direction once per step, and blocks 180-degree reversals.
- Advances the snake head on a cell grid and detects wall collision or wrap-around.
- Feeds the body/trail logic and the VGA renderer with head coordinates, a one-cycle step pulse and game_over.

---
 rtl/snake_pkg.sv | 36 +++
 rtl/snake_tick_gen.sv | 29 ++
 rtl/snake_head_mover.sv | 148 ++++++++++++++
 tb/tb_snake_head_mover.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared snake-game definitions: direction codes, FSM state encodings and grid geometry.
// The head mover, body/trail logic and VGA renderer all import this package.
package snake_pkg;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  localparam int GRID_W_DEF = 40;
  localparam int GRID_H_DEF = 30;
  localparam int CELL_SIZE  = 16;

  function automatic logic is_valid_dir(input logic [2:0] d);
    return (d >= DIR_UP) && (d <= DIR_RIGHT);
  endfunction

  // A move straight back into the body's own neck is a reversal.
  function automatic logic is_opposite(input logic [2:0] a, input logic [2:0] b);
    case (a)
      DIR_UP:    return b == DIR_DOWN;
      DIR_DOWN:  return b == DIR_UP;
      DIR_LEFT:  return b == DIR_RIGHT;
      DIR_RIGHT: return b == DIR_LEFT;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Game-step prescaler: counts enabled cycles and strobes tc on the last one of each period.
module snake_tick_gen #(
  parameter int TICK_DIV = 6250000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snake_head_mover.sv
// Snake head controller: commits a direction once per game step, refuses reversals,
// moves the head on the cell grid and ends the game on a wall hit (or wraps).
module snake_head_mover
  import snake_pkg::*;
#(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int TICK_DIV = 6250000,
  parameter int START_X  = 20,
  parameter int START_Y  = 15,
  parameter int WRAP     = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2:0]     dir_in,
  input  logic           pause,
  input  logic           restart,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic [2:0]     cur_dir,
  output logic           step_pulse,
  output logic           game_over,
  output logic [1:0]     state
);

  localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0] X0    = X_W'(START_X);
  localparam logic [Y_W-1:0] Y0    = Y_W'(START_Y);

  state_t         state_q;
  logic [2:0]     pending_dir;
  logic           tc;
  logic           running;
  logic [2:0]     ref_dir;
  logic           accept_dir;
  logic [X_W-1:0] next_x;
  logic [Y_W-1:0] next_y;
  logic           hit_wall;

  assign running = (state_q == ST_RUN);
  assign state   = state_q;

  snake_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (running && !pause),
    .clr  (!running),
    .tc   (tc)
  );

  // On a step edge the direction about to be committed is the one a new request must not reverse.
  assign ref_dir    = tc ? pending_dir : cur_dir;
  assign accept_dir = is_valid_dir(dir_in) && !is_opposite(dir_in, ref_dir);

  always_comb begin
    next_x   = head_x;
    next_y   = head_y;
    hit_wall = 1'b0;
    case (pending_dir)
      DIR_UP: begin
        if (head_y == '0) begin
          if (WRAP != 0) next_y = Y_MAX;
          else           hit_wall = 1'b1;
        end else begin
          next_y = head_y - 1'b1;
        end
      end
      DIR_DOWN: begin
        if (head_y == Y_MAX) begin
          if (WRAP != 0) next_y = '0;
          else           hit_wall = 1'b1;
        end else begin
          next_y = head_y + 1'b1;
        end
      end
      DIR_LEFT: begin
        if (head_x == '0) begin
          if (WRAP != 0) next_x = X_MAX;
          else           hit_wall = 1'b1;
        end else begin
          next_x = head_x - 1'b1;
        end
      end
      DIR_RIGHT: begin
        if (head_x == X_MAX) begin
          if (WRAP != 0) next_x = '0;
          else           hit_wall = 1'b1;
        end else begin
          next_x = head_x + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      head_x      <= X0;
      head_y      <= Y0;
      cur_dir     <= DIR_NONE;
      pending_dir <= DIR_NONE;
      step_pulse  <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (is_valid_dir(dir_in)) begin
            pending_dir <= dir_in;
            state_q     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept_dir) pending_dir <= dir_in;
          if (tc) begin
            cur_dir <= pending_dir;
            if (hit_wall) begin
              state_q   <= ST_DEAD;
              game_over <= 1'b1;
            end else begin
              head_x     <= next_x;
              head_y     <= next_y;
              step_pulse <= 1'b1;
            end
          end
        end
        ST_DEAD: begin
          if (restart) begin
            state_q     <= ST_IDLE;
            head_x      <= X0;
            head_y      <= Y0;
            cur_dir     <= DIR_NONE;
            pending_dir <= DIR_NONE;
            game_over   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_head_mover.sv
// Bench for snake_head_mover on a small 8x6 grid with a 4-cycle step, one wall instance and one wrap instance.
`timescale 1ns/1ps
module tb_snake_head_mover;
  import snake_pkg::*;

  localparam int TD = 4;
  localparam int GW = 8;
  localparam int GH = 6;
  localparam int SX = 4;
  localparam int SY = 3;
  localparam int XW = 6;
  localparam int YW = 5;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [2:0]    d;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, pause, restart, w_reset;
  logic [2:0]    dir_in, w_dir;
  logic [XW-1:0] head_x, w_head_x;
  logic [YW-1:0] head_y, w_head_y;
  logic [2:0]    cur_dir, w_cur_dir;
  logic          step_pulse, w_step_pulse, game_over, w_game_over;
  logic [1:0]    state, w_state;

  exp_t exp_q[$];
  exp_t exp_wq[$];
  exp_t mon_e, mon_we;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  snake_head_mover #(
    .GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW), .TICK_DIV(TD),
    .START_X(SX), .START_Y(SY), .WRAP(0)
  ) dut (
    .clk(clk), .reset(reset), .dir_in(dir_in), .pause(pause), .restart(restart),
    .head_x(head_x), .head_y(head_y), .cur_dir(cur_dir), .step_pulse(step_pulse),
    .game_over(game_over), .state(state)
  );

  snake_head_mover #(
    .GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW), .TICK_DIV(TD),
    .START_X(SX), .START_Y(SY), .WRAP(1)
  ) dut_w (
    .clk(clk), .reset(w_reset), .dir_in(w_dir), .pause(pause), .restart(restart),
    .head_x(w_head_x), .head_y(w_head_y), .cur_dir(w_cur_dir), .step_pulse(w_step_pulse),
    .game_over(w_game_over), .state(w_state)
  );

  function automatic exp_t mk(input int x, input int y, input logic [2:0] d);
    return exp_t'{XW'(x), YW'(y), d};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Every step_pulse must match the next queued head position and direction.
  always @(negedge clk) begin
    if (step_pulse === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL step_wall unexpected step_pulse head=(%0d,%0d) dir=%0d, expected no step", head_x, head_y, cur_dir);
      end else begin
        mon_e = exp_q.pop_front();
        if ({head_x, head_y, cur_dir} !== mon_e)
          $display("[TB] FAIL step_wall head=(%0d,%0d) dir=%0d expected (%0d,%0d) dir=%0d", head_x, head_y, cur_dir, mon_e.x, mon_e.y, mon_e.d);
        else n_pass++;
      end
    end
    if (w_step_pulse === 1'b1) begin
      n_checks++;
      if (exp_wq.size() == 0) begin
        $display("[TB] FAIL step_wrap unexpected step_pulse head=(%0d,%0d) dir=%0d, expected no step", w_head_x, w_head_y, w_cur_dir);
      end else begin
        mon_we = exp_wq.pop_front();
        if ({w_head_x, w_head_y, w_cur_dir} !== mon_we)
          $display("[TB] FAIL step_wrap head=(%0d,%0d) dir=%0d expected (%0d,%0d) dir=%0d", w_head_x, w_head_y, w_cur_dir, mon_we.x, mon_we.y, mon_we.d);
        else n_pass++;
      end
    end
  end

  task automatic test_reset();
    dir_in = DIR_RIGHT;
    step(2);
    n_checks++; if (state !== 2'd0) $display("[TB] FAIL reset_state got %0d expected 0", state); else n_pass++;
    n_checks++; if (head_x !== XW'(SX) || head_y !== YW'(SY)) $display("[TB] FAIL reset_head got (%0d,%0d) expected (%0d,%0d)", head_x, head_y, SX, SY); else n_pass++;
    n_checks++; if (cur_dir !== 3'd0) $display("[TB] FAIL reset_dir got %0d expected 0", cur_dir); else n_pass++;
    n_checks++; if (step_pulse !== 1'b0 || game_over !== 1'b0) $display("[TB] FAIL reset_flags got pulse=%0b over=%0b expected 0/0", step_pulse, game_over); else n_pass++;
    reset  = 1'b1;
    dir_in = DIR_NONE;
    step(1);
    n_checks++; if (state !== 2'd0) $display("[TB] FAIL idle_hold got %0d expected 0", state); else n_pass++;
  endtask

  task automatic test_run_right();
    dir_in = DIR_RIGHT;
    exp_q.push_back(mk(5, 3, DIR_RIGHT));
    exp_q.push_back(mk(6, 3, DIR_RIGHT));
    exp_q.push_back(mk(7, 3, DIR_RIGHT));
    step(1);
    dir_in = DIR_NONE;
    n_checks++; if (state !== 2'd1 || cur_dir !== 3'd0) $display("[TB] FAIL enter_run got state=%0d dir=%0d expected 1/0", state, cur_dir); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      step(3);
      n_checks++; if (step_pulse !== 1'b0) $display("[TB] FAIL step_early got %0b expected 0 (step %0d)", step_pulse, k); else n_pass++;
      step(1);
      n_checks++; if (step_pulse !== 1'b1) $display("[TB] FAIL step_period got %0b expected 1 (step %0d)", step_pulse, k); else n_pass++;
    end
  endtask

  task automatic test_wall();
    step(4);
    n_checks++; if (step_pulse !== 1'b0) $display("[TB] FAIL wall_pulse got %0b expected 0", step_pulse); else n_pass++;
    n_checks++; if (state !== 2'd2 || game_over !== 1'b1) $display("[TB] FAIL wall_dead got state=%0d over=%0b expected 2/1", state, game_over); else n_pass++;
    n_checks++; if (head_x !== 6'd7 || head_y !== 5'd3) $display("[TB] FAIL wall_head got (%0d,%0d) expected (7,3)", head_x, head_y); else n_pass++;
    pause  = 1'b1;
    dir_in = DIR_LEFT;
    step(3);
    n_checks++; if (state !== 2'd2 || head_x !== 6'd7) $display("[TB] FAIL dead_frozen got state=%0d x=%0d expected 2/7", state, head_x); else n_pass++;
    pause   = 1'b0;
    dir_in  = DIR_NONE;
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    n_checks++; if (state !== 2'd0 || game_over !== 1'b0) $display("[TB] FAIL restart_state got state=%0d over=%0b expected 0/0", state, game_over); else n_pass++;
    n_checks++; if (head_x !== XW'(SX) || head_y !== YW'(SY) || cur_dir !== 3'd0) $display("[TB] FAIL restart_head got (%0d,%0d) dir=%0d expected (4,3) dir=0", head_x, head_y, cur_dir); else n_pass++;
    step(5);
    n_checks++; if (state !== 2'd0) $display("[TB] FAIL restart_idle got %0d expected 0", state); else n_pass++;
  endtask

  task automatic test_reversal();
    dir_in = DIR_RIGHT;
    exp_q.push_back(mk(5, 3, DIR_RIGHT));
    exp_q.push_back(mk(6, 3, DIR_RIGHT));
    exp_q.push_back(mk(6, 2, DIR_UP));
    exp_q.push_back(mk(6, 1, DIR_UP));
    exp_q.push_back(mk(6, 0, DIR_UP));
    exp_q.push_back(mk(5, 0, DIR_LEFT));
    step(1);
    dir_in = DIR_NONE;
    step(4);
    n_checks++; if (step_pulse !== 1'b1) $display("[TB] FAIL rev_first got %0b expected 1", step_pulse); else n_pass++;
    dir_in = DIR_LEFT;
    step(4);
    n_checks++; if (step_pulse !== 1'b1 || cur_dir !== DIR_RIGHT) $display("[TB] FAIL rev_reject got pulse=%0b dir=%0d expected 1/4", step_pulse, cur_dir); else n_pass++;
    dir_in = DIR_UP;
    step(1);
    dir_in = DIR_NONE;
    step(2);
    dir_in = DIR_DOWN;
    step(1);
    dir_in = DIR_NONE;
    n_checks++; if (step_pulse !== 1'b1 || cur_dir !== DIR_UP) $display("[TB] FAIL up_taken got pulse=%0b dir=%0d expected 1/1", step_pulse, cur_dir); else n_pass++;
    step(4);
    n_checks++; if (step_pulse !== 1'b1 || cur_dir !== DIR_UP) $display("[TB] FAIL down_rejected got pulse=%0b dir=%0d expected 1/1", step_pulse, cur_dir); else n_pass++;
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    n_checks++; if (state !== 2'd1) $display("[TB] FAIL restart_in_run got %0d expected 1", state); else n_pass++;
    step(2);
    dir_in = DIR_LEFT;
    step(1);
    dir_in = DIR_NONE;
    n_checks++; if (step_pulse !== 1'b1 || cur_dir !== DIR_UP) $display("[TB] FAIL edge_old_dir got pulse=%0b dir=%0d expected 1/1", step_pulse, cur_dir); else n_pass++;
    step(4);
    n_checks++; if (step_pulse !== 1'b1 || cur_dir !== DIR_LEFT) $display("[TB] FAIL edge_next_dir got pulse=%0b dir=%0d expected 1/3", step_pulse, cur_dir); else n_pass++;
  endtask

  task automatic test_pause();
    int seen;
    seen = 0;
    exp_q.push_back(mk(4, 0, DIR_LEFT));
    step(2);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (step_pulse === 1'b1) seen++;
    end
    pause = 1'b0;
    n_checks++; if (seen !== 0) $display("[TB] FAIL pause_hold got %0d pulses expected 0", seen); else n_pass++;
    step(1);
    n_checks++; if (step_pulse !== 1'b0) $display("[TB] FAIL pause_resume_early got %0b expected 0", step_pulse); else n_pass++;
    step(1);
    n_checks++; if (step_pulse !== 1'b1) $display("[TB] FAIL pause_resume got %0b expected 1", step_pulse); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    step(3);
    reset = 1'b0;
    step(1);
    n_checks++; if (state !== 2'd0 || step_pulse !== 1'b0) $display("[TB] FAIL midrun_reset got state=%0d pulse=%0b expected 0/0", state, step_pulse); else n_pass++;
    n_checks++; if (head_x !== XW'(SX) || head_y !== YW'(SY) || cur_dir !== 3'd0) $display("[TB] FAIL midrun_head got (%0d,%0d) dir=%0d expected (4,3) dir=0", head_x, head_y, cur_dir); else n_pass++;
    reset = 1'b1;
    step(4);
    n_checks++; if (state !== 2'd0) $display("[TB] FAIL midrun_idle got %0d expected 0", state); else n_pass++;
  endtask

  task automatic test_wrap();
    w_reset = 1'b1;
    w_dir   = DIR_LEFT;
    for (int x = 3; x >= 0; x--) exp_wq.push_back(mk(x, 3, DIR_LEFT));
    for (int x = 7; x >= 2; x--) exp_wq.push_back(mk(x, 3, DIR_LEFT));
    exp_wq.push_back(mk(2, 2, DIR_UP));
    exp_wq.push_back(mk(2, 1, DIR_UP));
    exp_wq.push_back(mk(2, 0, DIR_UP));
    exp_wq.push_back(mk(2, 5, DIR_UP));
    step(1);
    w_dir = DIR_NONE;
    step(20);
    n_checks++; if (w_state !== 2'd1 || w_head_x !== 6'd7 || w_head_y !== 5'd3) $display("[TB] FAIL wrap_x got state=%0d (%0d,%0d) expected 1 (7,3)", w_state, w_head_x, w_head_y); else n_pass++;
    step(20);
    w_dir = DIR_UP;
    step(1);
    w_dir = DIR_NONE;
    step(15);
    n_checks++; if (w_state !== 2'd1 || w_head_x !== 6'd2 || w_head_y !== 5'd5 || w_step_pulse !== 1'b1) $display("[TB] FAIL wrap_y got state=%0d (%0d,%0d) pulse=%0b expected 1 (2,5) 1", w_state, w_head_x, w_head_y, w_step_pulse); else n_pass++;
    w_reset = 1'b0;
    step(1);
    w_reset = 1'b1;
  endtask

  task automatic test_drain();
    step(2);
    n_checks++; if (exp_q.size() !== 0) $display("[TB] FAIL wall_queue_left got %0d entries expected 0", exp_q.size()); else n_pass++;
    n_checks++; if (exp_wq.size() !== 0) $display("[TB] FAIL wrap_queue_left got %0d entries expected 0", exp_wq.size()); else n_pass++;
  endtask

  initial begin
    reset   = 1'b0;
    w_reset = 1'b0;
    dir_in  = DIR_NONE;
    w_dir   = DIR_NONE;
    pause   = 1'b0;
    restart = 1'b0;
    test_reset();
    test_run_right();
    test_wall();
    test_reversal();
    test_pause();
    test_reset_mid_run();
    test_wrap();
    test_drain();
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
